fp_convert_arbiter: RTL

- Round-robin arbiter and sequencer that shares one combinational FloatingPointConverter among N_REQ requesters.
- The converter maps a 12-bit two's-complement d to a 1-bit sign s, a 3-bit exponent e and a 4-bit significand f.
- This block accepts one request at a time and drives the captured word to the converter.
- It registers the converter result after a settle cycle and returns it, tagged with the requester id, over a valid/ready output handshake.

---
 rtl/fp_convert_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fp_convert_arbiter.sv
// Round-robin front end that time-shares one combinational float converter
// among N_REQ requesters and returns each result tagged with its requester id.
module fp_convert_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [12*N_REQ-1:0]   req_d,
  output logic [N_REQ-1:0]      req_ready,
  output logic [11:0]           conv_d,
  input  logic                  conv_s,
  input  logic [2:0]            conv_e,
  input  logic [3:0]            conv_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_s,
  output logic [2:0]            out_e,
  output logic [3:0]            out_f,
  output logic                  busy
);

  localparam int unsigned D_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic [D_W-1:0]  grant_word;

  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned v);
    return ID_W'(v % N_REQ);
  endfunction

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = wrap_idx(32'(rr_ptr) + k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_word = req_d[32'(grant_idx) * D_W +: D_W];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready = N_REQ'(1) << grant_idx;
    end
  end

  // Sequencer: capture word, let the converter settle one cycle, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      conv_d    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            conv_d <= grant_word;
            out_id <= grant_idx;
            rr_ptr <= wrap_idx(32'(grant_idx) + 32'd1);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          out_s     <= conv_s;
          out_e     <= conv_e;
          out_f     <= conv_f;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
